// File: rtl/loader_pkg.sv
// Shared definitions for the program loader.
//   state_e       : loader FSM states (CHECK exists only when LOADER_CHECKSUM_EN
//                   is defined)
//   HDR_LEN_BYTES : length of the little-endian word-count header
//   CSUM_W        : width of the checksum byte (also the stream byte width)
// Optional feature macro: LOADER_CHECKSUM_EN
package loader_pkg;

   localparam int unsigned HDR_LEN_BYTES = 2;
   localparam int unsigned CSUM_W        = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_COLLECT,
      S_WRITE,
      S_DONE
`ifdef LOADER_CHECKSUM_EN
      , S_CHECK
`endif
   } state_e;

endpackage

// File: rtl/prog_loader_if.sv
// Bundle of the loader's control, byte-stream and instruction-memory signals.
//   master : stream/control source side (drives start, byte_valid, byte_data)
//   slave  : the loader itself (drives byte_ready, im_*, core_hold, busy,
//            done, err)
interface prog_loader_if;

   logic        start;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        im_wr;
   logic [31:0] im_addr;
   logic [31:0] im_data;
   logic        core_hold;
   logic        busy;
   logic        done;
   logic        err;

   modport master (
      output start, byte_valid, byte_data,
      input  byte_ready, im_wr, im_addr, im_data, core_hold, busy, done, err
   );

   modport slave (
      input  start, byte_valid, byte_data,
      output byte_ready, im_wr, im_addr, im_data, core_hold, busy, done, err
   );

endinterface

// File: rtl/prog_loader_word_asm.sv
// word_asm: gathers four stream bytes into one little-endian 32-bit word.
//   clk, rst : clock, async active-high reset
//   clr_i    : drop any partial word and restart at byte 0
//   shift_i  : a byte transfer happened this cycle
//   byte_i   : the transferred byte
//   word_o   : assembled word (first byte in bits [7:0])
//   full_o   : this transfer is the 4th byte of the word
module word_asm
   import loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              shift_i,
   input  logic [CSUM_W-1:0] byte_i,
   output logic [31:0]       word_o,
   output logic              full_o
);

   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] word_q, word_d;

   // Shifting in from the top leaves the first byte in [7:0] after four shifts.
   always_comb begin
      cnt_d  = cnt_q;
      word_d = word_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (shift_i) begin
         word_d = {byte_i, word_q[31:CSUM_W]};
         cnt_d  = cnt_q + 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         word_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         word_q <= word_d;
      end
   end

   assign word_o = word_q;
   assign full_o = shift_i && !clr_i && (cnt_q == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed byte stream and writes it word by
// word into instruction memory while holding the core.
//   clk, rst : clock, async active-high reset
//   bus      : prog_loader_if.slave (start, byte stream, im write port,
//              core_hold, busy, done, err)
// Parameters: BASE_ADDR (byte address of word 0), DEPTH_WORDS (capacity).
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte).
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start
// LEN_LO  | accepting low byte of word count N
// LEN_HI  | accepting high byte of N; N==0 or N>DEPTH_WORDS ends the load
// COLLECT | accepting the 4 bytes of the current word
// WRITE   | one-cycle instruction memory write
// CHECK   | accepting the checksum byte (LOADER_CHECKSUM_EN only)
// DONE    | one-cycle completion pulse
module prog_loader
   import loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned DEPTH_WORDS = 256
) (
   input  logic         clk,
   input  logic         rst,
   prog_loader_if.slave bus
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS + 1);
   localparam int unsigned LEN_W = 8 * HDR_LEN_BYTES;

   state_e           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             err_q, err_d;
   logic             byte_rdy;
   logic             xfer;
   logic             asm_full;
   logic [31:0]      asm_word;
   logic [LEN_W-1:0] n_hdr;
   logic             idx_last;
`ifdef LOADER_CHECKSUM_EN
   logic [CSUM_W-1:0] csum_q, csum_d;
`endif

   assign byte_rdy = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
`ifdef LOADER_CHECKSUM_EN
                     (state_q == S_CHECK) ||
`endif
                     (state_q == S_COLLECT);
   assign xfer     = byte_rdy && bus.byte_valid;
   assign n_hdr    = {bus.byte_data, len_q[7:0]};
   assign idx_last = (LEN_W'(idx_q) + LEN_W'(1)) == len_q;

   // The assembler is held clear in IDLE so every load starts on byte 0.
   word_asm u_word_asm (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (state_q == S_IDLE),
      .shift_i (xfer && (state_q == S_COLLECT)),
      .byte_i  (bus.byte_data),
      .word_o  (asm_word),
      .full_o  (asm_full)
   );

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      err_d   = err_q;
`ifdef LOADER_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_LEN_LO;
               err_d   = 1'b0;
               idx_d   = '0;
`ifdef LOADER_CHECKSUM_EN
               csum_d  = '0;
`endif
            end
         end
         S_LEN_LO: begin
            if (xfer) begin
               len_d   = {{(LEN_W-8){1'b0}}, bus.byte_data};
               state_d = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (xfer) begin
               len_d = n_hdr;
               if (n_hdr == '0) begin
                  state_d = S_DONE;
               end else if (32'(n_hdr) > DEPTH_WORDS) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_COLLECT;
               end
            end
         end
         S_COLLECT: begin
`ifdef LOADER_CHECKSUM_EN
            if (xfer) csum_d = csum_q ^ bus.byte_data;
`endif
            if (asm_full) state_d = S_WRITE;
         end
         S_WRITE: begin
            idx_d = idx_q + IDX_W'(1);
            if (idx_last) begin
`ifdef LOADER_CHECKSUM_EN
               state_d = S_CHECK;
`else
               state_d = S_DONE;
`endif
            end else begin
               state_d = S_COLLECT;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         S_CHECK: begin
            if (xfer) begin
               if (bus.byte_data != csum_q) err_d = 1'b1;
               state_d = S_DONE;
            end
         end
`endif
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         idx_q   <= '0;
         err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   assign bus.byte_ready = byte_rdy;
   assign bus.im_wr      = (state_q == S_WRITE);
   assign bus.im_addr    = (state_q == S_WRITE) ? (BASE_ADDR + (32'(idx_q) << 2)) : 32'h0;
   assign bus.im_data    = (state_q == S_WRITE) ? asm_word : 32'h0;
   assign bus.busy       = (state_q != S_IDLE);
   // The core stays held during reset itself, not only while loading.
   assign bus.core_hold  = rst || (state_q != S_IDLE);
   assign bus.done       = (state_q == S_DONE);
   assign bus.err        = err_q;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address of the first instruction word written.
REQ-002 Parameter DEPTH_WORDS, default 256, instruction memory capacity in 32-bit words.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a load; honoured only in IDLE.
REQ-006 byte_valid  input  1  source presents byte_data.
REQ-007 byte_data  input  8  stream byte.
REQ-008 byte_ready  output  1  loader accepts byte this cycle; a transfer occurs when byte_valid and byte_ready are both high.
REQ-009 im_wr  output  1  instruction memory write strobe, one cycle per word.
REQ-010 im_addr  output  32  byte address of the word written, valid while im_wr is high.
REQ-011 im_data  output  32  word written, valid while im_wr is high.
REQ-012 core_hold  output  1  holds the processor (PC/register update) while loading.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 err  output  1  sticky error flag, cleared only by the next accepted start or by rst.

Function
REQ-016 Stream format: 2-byte little-endian word count N, then 4N payload bytes, each word little-endian (first byte -> bits [7:0]).
REQ-017 States: IDLE, LEN_LO, LEN_HI, COLLECT, WRITE, DONE.
REQ-018 IDLE -> LEN_LO on start; on that transition err clears and the word index resets to 0.
REQ-019 LEN_LO -> LEN_HI on a transfer; LEN_HI -> COLLECT on a transfer, unless N==0 or N>DEPTH_WORDS.
REQ-020 From LEN_HI, N==0 goes to DONE with no writes and err low.
REQ-021 From LEN_HI, N>DEPTH_WORDS goes to DONE with no writes and err high.
REQ-022 COLLECT accepts 4 bytes, one per transfer, with no required gap; the 4th transfer goes to WRITE.
REQ-023 WRITE lasts exactly one cycle: im_wr=1, im_addr=BASE_ADDR+4*index, im_data=assembled word, byte_ready=0.
REQ-024 After WRITE, the index increments; if index==N the next state is DONE, otherwise COLLECT.
REQ-025 Latency: im_wr is asserted the cycle after the 4th byte transfer of each word.
REQ-026 byte_ready is high only in LEN_LO, LEN_HI and COLLECT (and the checksum phase, REQ-033); it never depends combinationally on byte_valid.
REQ-027 DONE lasts one cycle with done=1, then returns to IDLE.
REQ-028 core_hold is high from the cycle after an accepted start through the DONE cycle inclusive.
REQ-029 start while busy is ignored.
REQ-030 byte_valid while byte_ready is low has no effect; bytes are not buffered.
REQ-031 The index counter is wide enough for DEPTH_WORDS; the address never wraps, because N is bounded by REQ-021.

Reset
REQ-032 rst asserted, including mid-load, forces IDLE asynchronously with these output values:
- byte_ready=0, im_wr=0, im_addr=0, im_data=0, busy=0, done=0, err=0;
- core_hold=1 while rst is high and 0 after release;
- a partially assembled word is discarded and never written.

Configuration
REQ-033 With LOADER_CHECKSUM_EN defined:
- one extra byte follows the payload, equal to the XOR of all 4N payload bytes;
- a CHECK state accepts it after the last WRITE;
- a mismatch sets err; DONE follows either way;
- for N==0 the checksum byte is not expected.
REQ-034 Without LOADER_CHECKSUM_EN: no CHECK state and no checksum logic; err arises only from REQ-021.

Structure
REQ-035 Shared package loader_pkg holds the state enum, the 2-byte header length constant and the checksum byte width.
REQ-036 One sub-module, word_asm, shifts in bytes, counts 0..3 and flags a full word; the FSM, counters and outputs stay in prog_loader.

Verification
REQ-037 Bench covers these directed scenarios:
- start, stream 02 00 13 00 00 00 93 00 10 00 -> im_wr at 0x0 data 0x00000013, then at 0x4 data 0x00100093, done pulse, err=0.
- header 00 00 -> no im_wr, done one cycle after the LEN_HI transfer, core_hold released after done.
- DEPTH_WORDS=4, header 05 00 -> no im_wr, done=1, err=1; err stays high until the next start.
- byte_valid toggling 1/0 every cycle with 1 word -> same write as back-to-back; byte_ready low during WRITE.
- rst pulsed after 2 of 4 payload bytes, then a fresh 1-word load of 0xDEADBEEF -> single write at 0x0 data 0xDEADBEEF.
- LOADER_CHECKSUM_EN, 1 word EF BE AD DE, checksum 0x22 -> err=0; checksum 0x23 -> err=1.
